// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// Contents: FSM state enum, Booth step-code constants, default operand width.
package booth_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Step codes on {Q[0], Q-1}
  localparam logic [1:0] STEP_NOP0 = 2'b00;
  localparam logic [1:0] STEP_ADD  = 2'b01;
  localparam logic [1:0] STEP_SUB  = 2'b10;
  localparam logic [1:0] STEP_NOP1 = 2'b11;

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand / product handshake bundle for booth_seq_ctrl.
// master: producer of operands and consumer of products (drives in_valid,
//         multiplicand, multiplier, out_ready).
// slave:  the multiplier controller (drives in_ready, out_valid, product, busy).
interface booth_seq_ctrl_if
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then a
// 1-bit arithmetic right shift of {A, Q, Q-1}. Purely combinational.
// Ports: a_i/q_i/q_m1_i current register set, m_i sign-extended multiplicand;
//        a_nxt_c/q_nxt_c/q_m1_nxt_c register set after the step.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_m1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_nxt_c,
  output logic [WIDTH-1:0] q_nxt_c,
  output logic             q_m1_nxt_c
);

  logic [WIDTH:0] sum_c;

  always_comb begin
    sum_c = a_i;
    case ({q_i[0], q_m1_i})
      STEP_SUB: sum_c = a_i - m_i;
      STEP_ADD: sum_c = a_i + m_i;
      default:  sum_c = a_i;
    endcase
    a_nxt_c    = {sum_c[WIDTH], sum_c[WIDTH:1]};
    q_nxt_c    = {sum_c[0], q_i[WIDTH-1:1]};
    q_m1_nxt_c = q_i[0];
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller.
// Accepts a signed operand pair over bus (in_valid/in_ready), performs one
// Booth step per CALC cycle on A:Q:Q-1 and returns the signed 2*WIDTH product
// (out_valid/out_ready). busy is high in CALC and DONE.
// Ports: clk, rst_n (async active-low), bus (booth_seq_ctrl_if.slave).
// Optional macro BOOTH_SEQ_EARLY_TERM_EN: finish with one variable shift once
// the remaining steps are known to be pure shifts.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_seq_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   step_a_c;
  logic [WIDTH-1:0] step_q_c;
  logic             step_qm1_c;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i        (a_q),
    .q_i        (q_q),
    .q_m1_i     (qm1_q),
    .m_i        (m_q),
    .a_nxt_c    (step_a_c),
    .q_nxt_c    (step_q_c),
    .q_m1_nxt_c (step_qm1_c)
  );

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  localparam int unsigned RW = 2 * WIDTH + 2;

  logic [RW-1:0]    shifted_c;
  logic [WIDTH-1:0] rem_mask_c;
  logic             early_c;

  // Remaining steps are pure shifts when the unprocessed multiplier bits all
  // match Q-1, or when M is zero (every add/subtract is then a no-op).
  always_comb begin
    rem_mask_c = ~({WIDTH{1'b1}} << cnt_q);
    early_c    = (((q_q ^ {WIDTH{qm1_q}}) & rem_mask_c) == '0) || (m_q == '0);
    shifted_c  = RW'($signed({a_q, q_q, qm1_q}) >>> cnt_q);
  end
`endif

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = CALC;
          a_d     = '0;
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_d   = CW'(WIDTH);
        end
      end
      CALC: begin
        a_d   = step_a_c;
        q_d   = step_q_c;
        qm1_d = step_qm1_c;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = {step_a_c[WIDTH-1:0], step_q_c};
        end
`ifdef BOOTH_SEQ_EARLY_TERM_EN
        if (early_c) begin
          {a_d, q_d, qm1_d} = shifted_c;
          cnt_d             = '0;
          state_d           = DONE;
          product_d         = shifted_c[PW:1];
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered views of the next state
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == CALC) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      m_q         <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl (WIDTH=5): directed cases, back-pressure
// hold, mid-operation reset and a shuffled sweep of all 1024 operand pairs.
module tb_booth_seq_ctrl;

  localparam int unsigned W = 5;

  typedef struct {
    int prod;
    int acc;
    int lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   rand_bp;
  exp_t exp_q[$];

  booth_seq_ctrl_if #(.WIDTH(W)) bus ();

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sprod();
    logic signed [2*W-1:0] p;
    p = bus.product;
    return int'(p);
  endfunction

  // Issue one operand pair and push its expected result once accepted
  task automatic do_op(input int m, input int q, input int exp_prod);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid     = 1'b1;
    bus.multiplicand = W'(m);
    bus.multiplier   = W'(q);
    @(posedge clk);
    #1;
    e.prod = exp_prod;
    e.acc  = cyc;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    e.lat  = (m == 0 || q == 0) ? 1 : -1;
`else
    e.lat  = W;
`endif
    exp_q.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: latency on out_valid rise, product on handshake
  initial begin : monitor
    bit prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else if (exp_q[0].lat >= 0) begin
          chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end else begin
          chk("latency_range", ((cyc - exp_q[0].acc) >= 1 && (cyc - exp_q[0].acc) <= W) ? 1 : 0, 1);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("product_no_expect", sprod(), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", sprod(), e.prod);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // Random consumer back-pressure
  initial begin : bp_gen
    forever begin
      @(posedge clk);
      #2;
      if (rand_bp) bus.out_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin : main
    int pairs[1024];
    int hold_prod;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rand_bp  = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // Reset state
    #3;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_product", bus.product, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);

    // Directed products
    do_op(6, -9, -54);
    chk("busy_in_calc", bus.busy, 1);
    chk("in_ready_in_calc", bus.in_ready, 0);
    do_op(-16, -16, 256);
    do_op(15, -16, -240);
    do_op(0, -9, 0);
    drain();

    // Hold product while consumer stalls; new operands must be ignored
    bus.out_ready = 1'b0;
    hold_prod = -7 * 9;
    do_op(-7, 9, hold_prod);
    begin
      int waited;
      waited = 0;
      while (!bus.out_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      chk("hold_reach_done", bus.out_valid, 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.multiplicand = W'(3);
      bus.multiplier   = W'(3);
      #2;
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_product", sprod(), hold_prod);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    do_op(-5, 13 - 16, 15);
    drain();

    // Reset during the third CALC cycle aborts the operation
    do_op(5, 3, 15);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_abort_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_product", bus.product, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(7, 7, 49);
    drain();

    // Shuffled sweep of every operand pair under random back-pressure
    for (int i = 0; i < 1024; i++) pairs[i] = i;
    for (int i = 1023; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i));
      t = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = t;
    end
    rand_bp = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      int m;
      int q;
      m = (pairs[i] >> 5) - 16;
      q = (pairs[i] & 31) - 16;
      do_op(m, q, m * q);
    end
    drain();
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequential radix-2 Booth multiplier controller. It accepts a signed multiplicand/multiplier pair over a valid/ready handshake and sequences one add/subtract-and-arithmetic-shift step per clock on an internal A:Q:Q₋₁ register set. It returns the signed 2·WIDTH product over a second valid/ready handshake. It replaces the stimulus-driven iteration used in the bench, so the multiplier can sit on a shared datapath bus.

## Interface
- WIDTH, default 5: operand width in bits, two's complement, minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  controller can accept; equals (state == IDLE).
- multiplicand  in  WIDTH  signed M; sampled on accept.
- multiplier  in  WIDTH  signed Q; sampled on accept.
- out_valid  out  1  product valid; equals (state == DONE).
- out_ready  in  1  consumer takes product.
- product  out  2·WIDTH  signed M×Q.
- busy  out  1  high in CALC or DONE.

## Operation
- Clocking and reset are fixed: one clock `clk`, asynchronous active-low reset `rst_n`.
- FSM states: IDLE, CALC, DONE.
- IDLE to CALC on accept (in_valid && in_ready):
  - A ← 0, with A being WIDTH+1 bits wide.
  - Q ← multiplier; Q₋₁ ← 0.
  - M ← sign-extend(multiplicand) to WIDTH+1 bits.
  - cnt ← WIDTH.
- Each CALC cycle performs one step:
  - {Q[0],Q₋₁} = 10: A ← A − M.
  - {Q[0],Q₋₁} = 01: A ← A + M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {A,Q,Q₋₁} by 1, replicating A's MSB.
  - cnt ← cnt − 1.
- CALC to DONE when cnt reaches 0 after a step. On that edge, product ← {A[WIDTH−1:0], Q}.
- DONE to IDLE on out_ready. out_valid and product hold stable until the handshake completes.
- The extra A bit makes −2^(W−1) × −2^(W−1) exact; there is no overflow for any input pair.
- in_valid is ignored outside IDLE. There is no back-to-back accept in DONE.
- Reset values: in_ready=0 while rst_n low, then 1 in IDLE. out_valid=0, busy=0, product=0. A, Q, Q₋₁, M, cnt are all 0.
- Reset mid-operation aborts the operation immediately. No result is produced, and the FSM returns to IDLE.
- product keeps its last value after DONE→IDLE. It is meaningful only while out_valid=1.

## Timing
- Accept edge = edge 0. With early termination off, out_valid rises after edge WIDTH, giving a fixed latency of WIDTH cycles.
- out_valid falls on the first edge with out_ready=1. in_ready is high the cycle after that edge.
- Throughput is one product per WIDTH+2 cycles, assuming out_ready is held high.
- No combinational path from in_valid or out_ready to any output.

## Configuration
- Macro: BOOTH_SEQ_EARLY_TERM_EN.
- Defined: at the start of each CALC cycle, check whether the unprocessed multiplier bits Q[cnt−1:0] all equal Q₋₁. If so, the remaining steps are pure shifts:
  - Shift {A,Q,Q₋₁} arithmetically right by cnt in one cycle.
  - Set cnt ← 0 and go to DONE.
  - Latency becomes 1..WIDTH cycles, data-dependent.
- Undefined: the early-termination check is absent and latency is always WIDTH.
- The product is identical in both builds.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE/CALC/DONE);
  - the step-code constants for 10/01/00/11;
  - the default WIDTH localparam.
- One natural sub-module, booth_step: a combinational block that takes A, Q, Q₋₁ and M and returns the next A, Q and Q₋₁ (add/sub plus 1-bit arithmetic shift).
- booth_seq_ctrl holds the FSM, the registers, the counter and the optional variable-shift path.

## Test plan
All cases use WIDTH=5.
- 6 × −9 (00110 × 10111): product = 10'b1111001010 (−54). out_valid exactly 5 cycles after accept when early termination is off.
- −16 × −16: product = 10'b0100000000 (+256); checks the extra A bit.
- 15 × −16 and 0 × −9: −240 and 0. With BOOTH_SEQ_EARLY_TERM_EN, 0 × −9 reaches out_valid 1 cycle after accept.
- out_ready held low 10 cycles in DONE: product and out_valid stable, in_ready=0, new in_valid ignored. Release it, then accept the next pair the following cycle.
- rst_n pulsed low in the 3rd CALC cycle: out_valid, busy and product go to 0 asynchronously. The next operation, 7 × 7, yields 49.
- Random sweep of all 1024 operand pairs in both build configurations: every product equals the signed reference product.
